// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Owns the program counter and sequences a combinational-read instruction
// memory. Each fetched word is captured together with its PC into a small
// FIFO fetch buffer. Decode drains the buffer through a valid/ready handshake.
// Execute can redirect the PC. A redirect flushes every wrong-path entry.
// A misaligned redirect target parks the unit in a sticky ERROR state, which
// only reset clears.
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous, active-low reset
//   fetch_enable     1 = fetching permitted, 0 = hold PC and push nothing
//   Inst_Address     byte address to instruction memory (always the PC)
//   Instruction      word returned by memory for Inst_Address, same cycle
//   redirect_valid   single-cycle pulse: load redirect_pc
//   redirect_pc      redirect target
//   out_valid        buffer head valid
//   out_ready        decode accepts the head this cycle
//   out_instruction  head instruction (holds last shown value when empty)
//   out_pc           PC of head instruction (holds last shown value when empty)
//   fetch_error      sticky flag: a misaligned redirect was seen
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_enable,
   output logic [63:0] Inst_Address,
   input  logic [31:0] Instruction,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [63:0] out_pc,
   output logic        fetch_error
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ERROR = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [63:0]        pc_reg, pc_next;
   logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0]   count_reg, count_next;

   // Fetch buffer storage. No reset is needed because count_reg alone decides
   // which entries are meaningful.
   logic [63:0]        buf_pc    [BUF_DEPTH];
   logic [31:0]        buf_instr [BUF_DEPTH];

   // Last head shown on out_*. When the buffer drains, the outputs keep
   // showing it.
   logic [63:0]        last_pc_reg;
   logic [31:0]        last_instr_reg;

   logic               redirect_ok;
   logic               redirect_bad;
   logic               buf_empty;
   logic               buf_full;
   logic               fetching;
   logic               pop;
   logic               push;

   // ------------------------------------------------------------------
   // Handshake and redirect decode
   // ------------------------------------------------------------------
   always_comb begin
      redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00) && (state_reg != ERROR);
      redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state_reg != ERROR);
      buf_empty    = (count_reg == '0);
      buf_full     = (count_reg == CNT_W'(BUF_DEPTH));
      // A redirect wins over the handshake. In that case the head is not consumed.
      pop          = !buf_empty && out_ready && !redirect_valid;
      // When the buffer is full, a same-cycle pop frees the slot being written.
      push         = fetching && !redirect_valid && (!buf_full || pop);
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (fetch_enable)  state_next = FETCH;
         FETCH:   if (!fetch_enable) state_next = IDLE;
         ERROR:   state_next = ERROR;
         default: state_next = IDLE;
      endcase
      if (redirect_bad) begin
         state_next = ERROR;
      end
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      // fetch_enable gates the push in the same cycle it drops. This way
      // "hold PC" takes effect without waiting for the state change.
      fetching    = (state_reg == FETCH) && fetch_enable;
      fetch_error = (state_reg == ERROR);
   end

   // ------------------------------------------------------------------
   // PC and buffer pointer next-state
   // ------------------------------------------------------------------
   always_comb begin
      pc_next     = pc_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (redirect_ok || redirect_bad) begin
         // Both flavours flush. Only an aligned target moves the PC.
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
         if (redirect_ok) begin
            pc_next = redirect_pc;
         end
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            pc_next     = pc_reg + 64'd4;   // natural 64-bit wrap
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_reg     <= RESET_PC;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         pc_reg     <= pc_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
      end
   end

   // ------------------------------------------------------------------
   // Buffer storage and last-shown head
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[wr_ptr_reg]    <= pc_reg;
         buf_instr[wr_ptr_reg] <= Instruction;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_pc_reg    <= '0;
         last_instr_reg <= '0;
      end else if (!buf_empty) begin
         last_pc_reg    <= buf_pc[rd_ptr_reg];
         last_instr_reg <= buf_instr[rd_ptr_reg];
      end
   end

   assign Inst_Address    = pc_reg;
   assign out_valid       = !buf_empty;
   assign out_pc          = buf_empty ? last_pc_reg    : buf_pc[rd_ptr_reg];
   assign out_instruction = buf_empty ? last_instr_reg : buf_instr[rd_ptr_reg];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed scenarios followed by a randomized run. A queue-based reference
// model tracks the expected buffer contents, PC and error flag, and every
// cycle the DUT outputs are checked against it. Key points of the directed
// scenarios also carry hand-derived constant expectations.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset_n;
   logic        fetch_enable;
   logic [63:0] inst_address;
   logic [31:0] instruction;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [63:0] out_pc;
   logic        fetch_error;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   instruction_fetch_unit #(
      .RESET_PC  (64'h0),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .fetch_enable    (fetch_enable),
      .Inst_Address    (inst_address),
      .Instruction     (instruction),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .fetch_error     (fetch_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: four program words, plus a hash everywhere else
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'd0:   return 32'h02853483;
         64'd4:   return 32'h009A84B3;
         64'd8:   return 32'h00148493;
         64'd12:  return 32'h00048863;
         default: return a[33:2] ^ a[63:32] ^ 32'h9E37_79B9;
      endcase
   endfunction

   assign instruction = mem_word(inst_address);

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q[$];
   logic [63:0] m_pc;
   logic        m_fetching;
   logic        m_error;
   logic [63:0] m_last_pc;
   logic [31:0] m_last_ins;

   task automatic model_reset();
      q.delete();
      m_pc       = 64'h0;
      m_fetching = 1'b0;
      m_error    = 1'b0;
      m_last_pc  = 64'h0;
      m_last_ins = 32'h0;
   endtask

   // Advances the model by one rising edge, using the inputs held before the edge
   task automatic model_edge();
      logic pop_m;
      logic push_m;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (q.size() > 0) begin
         m_last_pc  = q[0].pc;
         m_last_ins = q[0].ins;
      end
      if (m_error) return;
      if (redirect_valid) begin
         q.delete();
         if (redirect_pc[1:0] != 2'b00) m_error = 1'b1;
         else                           m_pc    = redirect_pc;
         m_fetching = fetch_enable;
         return;
      end
      pop_m  = (q.size() > 0) && out_ready;
      push_m = m_fetching && fetch_enable && ((q.size() < DEPTH) || pop_m);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
         q.push_back({m_pc, mem_word(m_pc)});
         m_pc = m_pc + 64'd4;
      end
      m_fetching = fetch_enable;
   endtask

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic        e_valid;
      logic [63:0] e_pc;
      logic [31:0] e_ins;
      e_valid = !m_error && (q.size() > 0);
      e_pc    = (q.size() > 0) ? q[0].pc  : m_last_pc;
      e_ins   = (q.size() > 0) ? q[0].ins : m_last_ins;
      chk("out_valid",       64'(out_valid),       64'(e_valid));
      chk("out_pc",          out_pc,               e_pc);
      chk("out_instruction", 64'(out_instruction), 64'(e_ins));
      chk("inst_address",    inst_address,         m_pc);
      chk("fetch_error",     64'(fetch_error),     64'(m_error));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Hold reset through one edge, then release with the given handshake inputs.
   task automatic do_reset(input logic en, input logic rdy);
      reset_n        = 1'b0;
      fetch_enable   = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      cycle();
      chk("rst_valid", 64'(out_valid),       64'h0);
      chk("rst_pc",    out_pc,               64'h0);
      chk("rst_ins",   64'(out_instruction), 64'h0);
      chk("rst_addr",  inst_address,         64'h0);
      chk("rst_err",   64'(fetch_error),     64'h0);
      reset_n      = 1'b1;
      fetch_enable = en;
      out_ready    = rdy;
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      reset_n        = 1'b0;
      fetch_enable   = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      model_reset();
      #1;
      check_all();

      // Streaming from reset: first valid entry two edges after release
      do_reset(1'b1, 1'b1);
      cycle();
      chk("a_valid_c1", 64'(out_valid), 64'h0);
      cycle();
      chk("a_pc0",  out_pc, 64'd0);  chk("a_ins0", 64'(out_instruction), 64'h02853483);
      cycle();
      chk("a_pc4",  out_pc, 64'd4);  chk("a_ins4", 64'(out_instruction), 64'h009A84B3);
      cycle();
      chk("a_pc8",  out_pc, 64'd8);  chk("a_ins8", 64'(out_instruction), 64'h00148493);
      cycle();
      chk("a_pc12", out_pc, 64'd12); chk("a_ins12", 64'(out_instruction), 64'h00048863);
      chk("a_valid", 64'(out_valid), 64'h1);

      // Stall, then full buffer with a push and a pop in the same cycle
      do_reset(1'b1, 1'b0);
      run(5);
      chk("b_hold_pc",   out_pc,          64'd0);
      chk("b_hold_addr", inst_address,    64'd8);
      chk("b_hold_vld",  64'(out_valid),  64'h1);
      out_ready = 1'b1;
      cycle();
      chk("e_head4", out_pc,       64'd4);
      chk("e_addr",  inst_address, 64'd12);
      out_ready = 1'b0;
      run(2);
      chk("e_full_head", out_pc,       64'd4);
      chk("e_full_addr", inst_address, 64'd12);
      out_ready = 1'b1;
      cycle();
      chk("b_head8",  out_pc, 64'd8);
      cycle();
      chk("b_head12", out_pc, 64'd12);

      // Redirect to 12 while the buffer holds pc 0 and 4
      do_reset(1'b1, 1'b0);
      run(5);
      redirect_valid = 1'b1;
      redirect_pc    = 64'd12;
      out_ready      = 1'b1;
      cycle();
      chk("c_valid", 64'(out_valid), 64'h0);
      chk("c_addr",  inst_address,   64'd12);
      redirect_valid = 1'b0;
      cycle();
      chk("c_pc",  out_pc,                64'd12);
      chk("c_ins", 64'(out_instruction),  64'h00048863);
      run(3);

      // Misaligned redirect: sticky error that only reset clears
      do_reset(1'b1, 1'b1);
      run(2);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h6;
      cycle();
      redirect_valid = 1'b0;
      chk("d_err",  64'(fetch_error), 64'h1);
      chk("d_vld",  64'(out_valid),   64'h0);
      chk("d_addr", inst_address,     64'd4);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h40;
      cycle();
      redirect_valid = 1'b0;
      run(3);
      chk("d_addr_hold", inst_address,     64'd4);
      chk("d_err_hold",  64'(fetch_error), 64'h1);
      do_reset(1'b1, 1'b1);
      chk("d_err_clr", 64'(fetch_error), 64'h0);

      // Redirect near the top of the address space: PC wraps to 0
      run(2);
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
      cycle();
      redirect_valid = 1'b0;
      run(3);
      chk("w_pc0",  out_pc,       64'd0);
      chk("w_addr", inst_address, 64'd4);

      // Asynchronous reset with no clock edge
      run(2);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("f_valid", 64'(out_valid),       64'h0);
      chk("f_pc",    out_pc,               64'h0);
      chk("f_ins",   64'(out_instruction), 64'h0);
      chk("f_addr",  inst_address,         64'h0);
      check_all();
      cycle();
      reset_n = 1'b1;

      // Randomized traffic with aligned redirects only
      for (int i = 0; i < 1500; i++) begin
         fetch_enable   = ($urandom_range(0, 9) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 3) == 0)
            redirect_pc = {$urandom, $urandom} & ~64'h3;
         else
            redirect_pc = 64'($urandom_range(0, 63)) << 2;
         cycle();
      end
      redirect_valid = 1'b0;
      run(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
